md_pad_6button: RTL and testbench
=================================

Name: md_pad_6button

Overview:
- Cycle-level model of a Mega Drive 6-button control pad, attached to one controller port of the 315-5216 I/O block.
- It consumes the port's TH line (pin value and direction) and produces the six active-low pad lines U, D, L, R, TL, TR that feed PORT_x_i[5:0].
- It implements the TH-toggle multiplex protocol, including the extra-button phase and the inactivity timeout that returns the pad to phase 0.
- One instance is used per port. With MODE6=0 it degenerates to a 3-button pad.

Parameters:
- MODE6, 1, 1 = 6-button protocol enabled; 0 = falling-edge count F held at 0 (plain 3-button pad).
- TIMEOUT, 80000, MCLK cycles without a TH falling edge before F returns to 0 (about 1.5 ms at 53.7 MHz).
- TW, 17, timer width in bits. Must satisfy 2^TW >= TIMEOUT.

Ports:
- MCLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous reset, active-high.
- TH_i  in  1  TH pin level driven by the I/O block (PORT_x_o[6]).
- TH_d  in  1  TH direction from the I/O block (PORT_x_d[6]); 1 = not driven, pin pulled up.
- BTN  in  12  buttons, active-high pressed: [0]U [1]D [2]L [3]R [4]A [5]B [6]C [7]Start [8]X [9]Y [10]Z [11]Mode.
- PAD_o  out  6  active-low pad lines {TR,TL,R,L,D,U}; bit order matches PORT_x_i[5:0].

Behaviour:
- Effective TH: th = TH_d ? 1 : TH_i.
- Registers:
  - th_q, 1 bit, reset value 1.
  - F, 3-bit falling-edge count, reset value 0, saturates at 4.
  - timer, TW bits, reset value 0.
  - PAD_o, reset value 6'h3F (nothing pressed).
- Falling edge: fall = th_q & ~th. th_q <= th every cycle.
- Update order within a cycle:
  - Timeout: if F != 0, timer == TIMEOUT-1 and no fall, then F <= 0 and timer <= 0.
  - Edge: if fall, F <= min(F+1, 4) and timer <= 0.
  - Otherwise, if F != 0, timer <= timer + 1.
  - If F == 0, timer holds 0.
  - With MODE6 = 0, F is forced to 0 and the timer is idle.
- Timeout coinciding with fall: fall wins; F increments from its current value and timer clears. Timeout is evaluated only when fall = 0.
- Output is registered. PAD_o <= ~sel, where sel is computed from the current th, the next F (Fn) and the current BTN.
  - th=1, Fn in {0,1,2,4}: {C,B,R,L,D,U}.
  - th=0, Fn in {0,1,2}: {Start,A,0,0,D,U}; L and R pins read low.
  - th=0, Fn=3: {Start,A,0,0,0,0}; U, D, L, R all read low.
  - th=1, Fn=3: {C,B,Mode,X,Y,Z}.
  - th=0, Fn=4: {Start,A,1,1,1,1}; pins U, D, L, R read high, i.e. sel bits are 0.
- Latency: a TH or BTN change is visible on PAD_o exactly one MCLK after it is presented.
- Further falling edges while F=4 keep F=4 and restart the timer.
- Reset mid-sequence: all registers return to their reset values on the next edge, regardless of TH or BTN.
- TH_d=1 with TH_i=0: treated as th=1. A direction change from 0 to 1 while TH_i=0 is a rising edge and does not count.

Test Plan:
- Reset released, TH_d=1, BTN=12'h000 -> PAD_o=6'h3F one cycle later; F=0.
- TH_d=0, TH_i=1, BTN[5]=1 (B) -> PAD_o=6'h2F. Drop TH_i to 0 with BTN[4]=1 (A) -> PAD_o=6'h23 (A low; L and R forced low).
- Four TH falling edges, each one 100 cycles apart, BTN[10]=1 (Z), BTN[11]=1 (Mode):
  - After the 3rd fall, th=0 -> PAD_o=6'h30.
  - Raise TH -> PAD_o=6'h36 (Z and Mode low).
  - 4th fall -> PAD_o=6'h3F.
- Timeout: reach F=3, then hold TH_i=1 for TIMEOUT cycles -> F=0 and PAD_o returns to the 3-button mapping. A fall at cycle TIMEOUT-2 instead yields F=4.
- Simultaneous: fall on exactly the cycle timer==TIMEOUT-1 with F=2 -> F=3, timer=0.
- MODE6=0: 10 TH toggles with BTN[8]=1 (X) -> PAD_o never shows X; th=0 always gives {S,A,0,0,D,U}.
- Assert RESET while F=3 and th=1 -> next cycle PAD_o=6'h3F and F=0.

Source files
------------

// File: rtl/md_pad_6button.sv
`default_nettype none
// ============================================================================
//  Module   : md_pad_6button
//  Purpose  : Cycle-level model of a Mega Drive 6-button control pad.
//             It watches the TH line of one 315-5216 controller port and
//             drives the six active-low pad lines {TR,TL,R,L,D,U}.
//             TH falling edges step the multiplex phase F (saturating at 4).
//             After the third falling edge, the pad exposes X/Y/Z/Mode.
//             An inactivity timer returns F to 0 when no further edges
//             arrive. With MODE6=0 the pad behaves as a plain 3-button pad.
//  Revision : 1.0  initial release
// ============================================================================
module md_pad_6button #(
  parameter int MODE6   = 1,      // 1 = 6-button protocol, 0 = 3-button pad
  parameter int TIMEOUT = 80000,  // MCLK cycles without a TH fall before F -> 0
  parameter int TW      = 17      // timer width, 2^TW >= TIMEOUT
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        TH_i,
  input  logic        TH_d,
  input  logic [11:0] BTN,
  output logic [5:0]  PAD_o
);

  // Phase values of the falling-edge count F that change the output mapping.
  localparam logic [2:0]    c_F_IDLE  = 3'd0;  // no edges seen / timed out
  localparam logic [2:0]    c_F_EXTRA = 3'd3;  // extra-button phase
  localparam logic [2:0]    c_F_SAT   = 3'd4;  // saturated after the 4th edge
  localparam logic [TW-1:0] c_TMAX    = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] c_TONE    = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [5:0]    c_IDLE    = 6'h3F;  // all lines high, nothing pressed

  // Button aliases (active-high pressed).
  logic w_up, w_dn, w_lf, w_rt, w_a, w_b, w_c, w_st, w_x, w_y, w_z, w_md;
  assign w_up = BTN[0];
  assign w_dn = BTN[1];
  assign w_lf = BTN[2];
  assign w_rt = BTN[3];
  assign w_a  = BTN[4];
  assign w_b  = BTN[5];
  assign w_c  = BTN[6];
  assign w_st = BTN[7];
  assign w_x  = BTN[8];
  assign w_y  = BTN[9];
  assign w_z  = BTN[10];
  assign w_md = BTN[11];

  logic          th_q;
  logic [2:0]    f_q,     f_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    pad_q,   pad_d;

  logic w_th;       // effective TH level (released line is pulled up)
  logic w_fall;     // TH falling edge this cycle
  logic w_timeout;  // inactivity timer expires this cycle

  assign w_th      = TH_d | TH_i;
  assign w_fall    = th_q & ~w_th;
  assign w_timeout = (f_q != c_F_IDLE) && (timer_q == c_TMAX);

  // Phase count and inactivity timer; a falling edge takes priority over timeout.
  always_comb begin
    f_d     = f_q;
    timer_d = timer_q;
    if (MODE6 == 0) begin
      f_d     = c_F_IDLE;
      timer_d = '0;
    end else if (w_fall) begin
      f_d     = (f_q >= c_F_SAT) ? c_F_SAT : f_q + 3'd1;
      timer_d = '0;
    end else if (w_timeout) begin
      f_d     = c_F_IDLE;
      timer_d = '0;
    end else if (f_q != c_F_IDLE) begin
      timer_d = timer_q + c_TONE;
    end else begin
      timer_d = '0;
    end
  end

  // Output line selection from current TH, next phase and current buttons.
  always_comb begin
    pad_d = c_IDLE;
    if (w_th) begin
      if (f_d == c_F_EXTRA) begin
        pad_d = ~{w_c, w_b, w_md, w_x, w_y, w_z};
      end else begin
        pad_d = ~{w_c, w_b, w_rt, w_lf, w_dn, w_up};
      end
    end else begin
      case (f_d)
        c_F_EXTRA: pad_d = {~w_st, ~w_a, 4'b0000};           // U/D/L/R read low
        c_F_SAT:   pad_d = {~w_st, ~w_a, 4'b1111};           // U/D/L/R read high
        default:   pad_d = {~w_st, ~w_a, 2'b00, ~w_dn, ~w_up}; // L/R read low
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      th_q    <= 1'b1;
      f_q     <= c_F_IDLE;
      timer_q <= '0;
      pad_q   <= c_IDLE;
    end else begin
      th_q    <= w_th;
      f_q     <= f_d;
      timer_q <= timer_d;
      pad_q   <= pad_d;
    end
  end

  assign PAD_o = pad_q;

endmodule
`default_nettype wire

// File: tb/tb_md_pad_6button.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_pad_6button
//  Purpose  : Self-checking bench for md_pad_6button (6-button and 3-button
//             instances driven in parallel, compared against a reference model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_pad_6button;

  localparam int TO  = 300;
  localparam int TWB = 9;

  logic        MCLK  = 1'b0;
  logic        RESET = 1'b1;
  logic        TH_i  = 1'b1;
  logic        TH_d  = 1'b1;
  logic [11:0] BTN   = 12'h000;
  logic [5:0]  pad6, pad3;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: previous effective TH, phase, cycles since last fall.
  logic       m_thp  = 1'b1;
  int         m_f    = 0;
  int         m_idle = 0;
  logic [5:0] e6, e3;

  always #5 MCLK = ~MCLK;

  md_pad_6button #(.MODE6(1), .TIMEOUT(TO), .TW(TWB)) u_dut6 (
    .MCLK(MCLK), .RESET(RESET), .TH_i(TH_i), .TH_d(TH_d), .BTN(BTN), .PAD_o(pad6)
  );

  md_pad_6button #(.MODE6(0), .TIMEOUT(TO), .TW(TWB)) u_dut3 (
    .MCLK(MCLK), .RESET(RESET), .TH_i(TH_i), .TH_d(TH_d), .BTN(BTN), .PAD_o(pad3)
  );

  // Pad lines as a real 6-button pad presents them for a given TH and phase.
  function automatic logic [5:0] exp_pad(input logic th, input int f, input logic [11:0] b);
    if (th) begin
      if (f == 3) return ~{b[6], b[5], b[11], b[8], b[9], b[10]};
      return ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    end
    if (f == 3) return {~b[7], ~b[4], 4'b0000};
    if (f == 4) return {~b[7], ~b[4], 4'b1111};
    return {~b[7], ~b[4], 2'b00, ~b[1], ~b[0]};
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model with the current inputs, clock once, compare both pads.
  task automatic step(input string tag);
    logic th, fall;
    th   = TH_d | TH_i;
    fall = m_thp & ~th;
    if (RESET) begin
      m_f = 0; m_idle = 0; m_thp = 1'b1;
      e6 = 6'h3F; e3 = 6'h3F;
    end else begin
      if (fall) begin
        m_f    = (m_f < 4) ? m_f + 1 : 4;
        m_idle = 0;
      end else if (m_f != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_f = 0; m_idle = 0;
        end
      end
      e6    = exp_pad(th, m_f, BTN);
      e3    = exp_pad(th, 0, BTN);
      m_thp = th;
    end
    @(posedge MCLK);
    #1;
    chk({tag, "/6btn"}, pad6, e6);
    chk({tag, "/3btn"}, pad3, e3);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_th(input logic v);
    TH_d = 1'b0;
    TH_i = v;
  endtask

  // Produce a falling edge exactly n clocks after the previous one (n >= 2).
  task automatic fall_after(input string tag, input int n);
    set_th(1'b1);
    run(tag, n - 1);
    set_th(1'b0);
    run(tag, 1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    run("reset", 2);
    RESET = 1'b0;
  endtask

  // Reset, then three falling edges a few cycles apart (F=3, th=0).
  task automatic reach_f3(input string tag);
    do_reset();
    set_th(1'b1); run(tag, 2);
    set_th(1'b0); run(tag, 1);
    fall_after(tag, 4);
    fall_after(tag, 4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  initial begin
    int len;

    // Reset state
    RESET = 1'b1; TH_d = 1'b1; TH_i = 1'b1; BTN = 12'h000;
    run("rst", 3);
    chk("rst_pad", pad6, 6'h3F);
    RESET = 1'b0;
    run("idle", 2);
    chk("idle_pad", pad6, 6'h3F);

    // Plain 3-button mapping, both TH levels
    set_th(1'b1); BTN = 12'h020; run("th1_b", 1);
    chk("th1_B", pad6, 6'h2F);
    set_th(1'b0); BTN = 12'h010; run("th0_a", 1);
    chk("th0_A", pad6, 6'h23);

    // Four falls 100 cycles apart with Z and Mode pressed
    do_reset();
    BTN = 12'hC00;
    set_th(1'b1); run("pre", 5);
    set_th(1'b0); run("f1", 1);
    fall_after("f2", 100);
    fall_after("f3", 100);
    chk("f3_th0", pad6, 6'h30);
    set_th(1'b1); run("f3_rise", 1);
    chk("f3_th1", pad6, 6'h36);
    run("f3_hold", 98);
    set_th(1'b0); run("f4", 1);
    chk("f4_th0", pad6, 6'h3F);
    fall_after("f5", 10);
    chk("f5_sat", pad6, 6'h3F);

    // Inactivity timeout from F=3
    reach_f3("to_pre");
    BTN = 12'hC00;
    set_th(1'b1); run("to_hold", TO - 1);
    chk("to_before", pad6, 6'h36);
    run("to_edge", 1);
    chk("to_after", pad6, 6'h3F);
    set_th(1'b0); run("to_fall", 1);
    chk("to_restart", pad6, 6'h33);

    // Fall at TIMEOUT-2 after the third one still reaches F=4
    BTN = 12'h000;
    reach_f3("l4_pre");
    fall_after("l4", TO - 2);
    chk("late_F4", pad6, 6'h3F);

    // Fall coinciding with the timeout cycle wins, timer restarts
    do_reset();
    set_th(1'b1); run("sim_pre", 2);
    set_th(1'b0); run("sim_pre", 1);
    fall_after("sim_pre", 5);
    fall_after("sim", TO);
    chk("sim_F3", pad6, 6'h30);
    fall_after("sim2", TO);
    chk("sim_F4", pad6, 6'h3F);

    // One cycle past the timeout the count restarts at 1
    do_reset();
    set_th(1'b1); run("past_pre", 2);
    set_th(1'b0); run("past_pre", 1);
    fall_after("past_pre", 5);
    fall_after("past", TO + 1);
    chk("past_F1", pad6, 6'h33);

    // Released TH reads high; direction change to driven-low is a fall
    do_reset();
    TH_d = 1'b1; TH_i = 1'b0; run("dir_rel", 2);
    chk("dir_rel", pad6, 6'h3F);
    TH_d = 1'b0; run("dir_drv", 1);
    chk("dir_fall", pad6, 6'h33);
    TH_d = 1'b1; run("dir_rel2", 3);

    // 3-button instance never shows X
    do_reset();
    BTN = 12'h100;
    for (int i = 0; i < 10; i++) begin
      set_th(i[0]); run("m3", 1);
      chk("m3_noX", pad3, i[0] ? 6'h3F : 6'h33);
    end

    // Reset in the extra-button phase
    BTN = 12'hC00;
    reach_f3("mid_pre");
    set_th(1'b1); run("mid_rise", 1);
    chk("mid_f3", pad6, 6'h36);
    RESET = 1'b1; run("mid_rst", 1);
    chk("mid_rst", pad6, 6'h3F);
    RESET = 1'b0;
    BTN = 12'h000;
    set_th(1'b0); run("mid_fall", 1);
    chk("mid_F1", pad6, 6'h33);

    // Randomised segments, some held near the timeout boundary
    for (int s = 0; s < 80; s++) begin
      BTN   = 12'($urandom);
      TH_i  = 1'($urandom_range(0, 1));
      TH_d  = ($urandom_range(0, 7) == 0);
      RESET = ($urandom_range(0, 31) == 0);
      len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 3, TO + 3))
                                          : int'($urandom_range(1, 6));
      run("rnd", len);
      RESET = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
